// File: rtl/lab4_sys_net_pkg.sv
// Shared ring-network definitions: port counts, port index type and the
// output-register state used by the switch stage.
package lab4_sys_net_pkg;

  localparam int unsigned NUM_IN_PORTS = 3;
  localparam int unsigned NUM_ROUTERS  = 4;

  typedef logic [1:0] port_idx_t;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_e;

  // The winner drops to lowest priority: pointer moves just past it, wrapping at 3.
  function automatic port_idx_t next_prio(input port_idx_t winner);
    return (winner == 2'd2) ? port_idx_t'(0) : port_idx_t'(winner + 2'd1);
  endfunction

endpackage

// File: rtl/lab4_sys_net_rr_arb3.sv
// Three-way round-robin arbiter; the priority pointer lives here and only
// advances when a grant is issued.
module lab4_sys_net_rr_arb3
  import lab4_sys_net_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN_PORTS-1:0] req,
  input  logic                    en,
  output logic [NUM_IN_PORTS-1:0] grant
);

  port_idx_t   prio;
  port_idx_t   prio_eff;
  port_idx_t   winner;
  port_idx_t   cand;
  logic        found;
  int unsigned pos;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= '0;
    end else if (found) begin
      prio <= next_prio(winner);
    end
  end

  always_comb begin
    prio_eff = (prio == 2'd3) ? port_idx_t'(0) : prio;
    grant    = '0;
    winner   = '0;
    cand     = '0;
    found    = 1'b0;
    pos      = 0;
    for (int unsigned k = 0; k < NUM_IN_PORTS; k++) begin
      pos  = (32'(prio_eff) + k) % NUM_IN_PORTS;
      cand = port_idx_t'(pos);
      if (en && !found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    if (found) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/lab4_sys_net_router_switch_unit.sv
// Output-side switch stage: arbitrates the three route-unit candidates into a
// single output register with 1-cycle latency and same-cycle drain/refill.
module lab4_sys_net_router_switch_unit
  import lab4_sys_net_pkg::*;
#(
  parameter int unsigned p_msg_nbits = 44
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_IN_PORTS-1:0][p_msg_nbits-1:0]  istream_msg,
  input  logic [NUM_IN_PORTS-1:0]                   istream_val,
  output logic [NUM_IN_PORTS-1:0]                   istream_rdy,
  output logic [p_msg_nbits-1:0]                    ostream_msg,
  output logic                                      ostream_val,
  input  logic                                      ostream_rdy
);

  out_state_e                state;
  out_state_e                state_nxt;
  logic                      can_load;
  logic                      arb_en;
  logic                      any_grant;
  logic [NUM_IN_PORTS-1:0]   grant;
  port_idx_t                 sel;

  assign can_load = (state == OUT_EMPTY) || ostream_rdy;
  // Gating with reset keeps every rdy low while reset is held, even though the
  // output register is already empty.
  assign arb_en   = can_load && reset;

  lab4_sys_net_rr_arb3 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (istream_val),
    .en    (arb_en),
    .grant (grant)
  );

  assign any_grant   = |grant;
  assign istream_rdy = grant;

  always_comb begin
    sel = '0;
    if (grant[2]) begin
      sel = 2'd2;
    end else if (grant[1]) begin
      sel = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: begin
        if (any_grant) begin
          state_nxt = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (any_grant) begin
          state_nxt = OUT_FULL;
        end else if (ostream_rdy) begin
          state_nxt = OUT_EMPTY;
        end
      end
      default: state_nxt = OUT_EMPTY;
    endcase
  end

  always_comb begin
    ostream_val = (state == OUT_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ostream_msg <= '0;
    end else if (any_grant) begin
      ostream_msg <= istream_msg[sel];
    end
  end

endmodule

// File: tb/tb_lab4_sys_net_router_switch_unit.sv
// Bench for the router switch stage: hand-computed vector table, async reset
// sequence, and random traffic against a distance-based round-robin model.
module tb_lab4_sys_net_router_switch_unit;

  localparam int W = 44;

  logic                clk = 1'b0;
  logic                reset;
  logic [2:0][W-1:0]   istream_msg;
  logic [2:0]          istream_val;
  logic [2:0]          istream_rdy;
  logic [W-1:0]        ostream_msg;
  logic                ostream_val;
  logic                ostream_rdy;

  always #5 clk = ~clk;

  lab4_sys_net_router_switch_unit #(.p_msg_nbits(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_msg (istream_msg),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .ostream_msg (ostream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   val;
    logic [W-1:0] m0, m1, m2;
    logic         ordy;
    logic [2:0]   erdy;
    logic         eoval;
    logic [W-1:0] emsg;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic [2:0] val, input logic [W-1:0] m0, m1, m2,
                              input logic ordy, input logic [2:0] erdy,
                              input logic eoval, input logic [W-1:0] emsg);
    vec_t v;
    v.val = val; v.m0 = m0; v.m1 = m1; v.m2 = m2; v.ordy = ordy;
    v.erdy = erdy; v.eoval = eoval; v.emsg = emsg;
    return v;
  endfunction

  // behavioural model state
  bit          m_val;
  logic [W-1:0] m_msg;
  int          m_prio;

  initial begin
    // expected outputs are those seen during the cycle, before its posedge
    vecs[0]  = mk(3'b001, 'hA0, 'hB1, 'hC2, 1, 3'b001, 0, 'h0);
    vecs[1]  = mk(3'b111, 'h10, 'h20, 'h30, 1, 3'b010, 1, 'hA0);
    vecs[2]  = mk(3'b111, 'h10, 'h20, 'h30, 1, 3'b100, 1, 'h20);
    vecs[3]  = mk(3'b111, 'h10, 'h20, 'h30, 1, 3'b001, 1, 'h30);
    vecs[4]  = mk(3'b111, 'h10, 'h20, 'h30, 1, 3'b010, 1, 'h10);
    vecs[5]  = mk(3'b111, 'h10, 'h20, 'h30, 1, 3'b100, 1, 'h20);
    vecs[6]  = mk(3'b111, 'h10, 'h20, 'h30, 1, 3'b001, 1, 'h30);
    vecs[7]  = mk(3'b010, 'h10, 'h11, 'h30, 1, 3'b010, 1, 'h10);
    vecs[8]  = mk(3'b111, 'h10, 'h20, 'h30, 0, 3'b000, 1, 'h11);
    vecs[9]  = mk(3'b111, 'h10, 'h20, 'h30, 0, 3'b000, 1, 'h11);
    vecs[10] = mk(3'b111, 'h10, 'h20, 'h30, 0, 3'b000, 1, 'h11);
    vecs[11] = mk(3'b111, 'h10, 'h20, 'h30, 1, 3'b100, 1, 'h11);
    vecs[12] = mk(3'b010, 'h10, 'h20, 'h30, 1, 3'b010, 1, 'h30);
    vecs[13] = mk(3'b101, 'h10, 'h20, 'h30, 1, 3'b100, 1, 'h20);
    vecs[14] = mk(3'b101, 'h10, 'h20, 'h30, 1, 3'b001, 1, 'h30);
    vecs[15] = mk(3'b000, 'h10, 'h20, 'h30, 1, 3'b000, 1, 'h10);
    vecs[16] = mk(3'b000, 'h10, 'h20, 'h30, 1, 3'b000, 0, 'h10);
    vecs[17] = mk(3'b000, 'h10, 'h20, 'h30, 1, 3'b000, 0, 'h10);
    vecs[18] = mk(3'b000, 'h10, 'h20, 'h30, 1, 3'b000, 0, 'h10);
    vecs[19] = mk(3'b000, 'h10, 'h20, 'h30, 1, 3'b000, 0, 'h10);
    vecs[20] = mk(3'b111, 'h10, 'h20, 'h30, 1, 3'b010, 0, 'h10);
    vecs[21] = mk(3'b000, 'h10, 'h20, 'h30, 0, 3'b000, 1, 'h20);

    // reset held with every input valid
    reset       = 1'b0;
    istream_val = 3'b111;
    istream_msg = '{W'('h33), W'('h22), W'('h11)};
    ostream_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_oval", 64'(ostream_val), 64'(0));
    chk("reset_rdy",  64'(istream_rdy), 64'(0));
    chk("reset_omsg", 64'(ostream_msg), 64'(0));

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b1;
      istream_val    = vecs[i].val;
      istream_msg[0] = vecs[i].m0;
      istream_msg[1] = vecs[i].m1;
      istream_msg[2] = vecs[i].m2;
      ostream_rdy    = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_rdy", i),  64'(istream_rdy), 64'(vecs[i].erdy));
      chk($sformatf("vec%0d_oval", i), 64'(ostream_val), 64'(vecs[i].eoval));
      chk($sformatf("vec%0d_omsg", i), 64'(ostream_msg), 64'(vecs[i].emsg));
    end

    // async reset between edges while FULL and stalled
    @(negedge clk);
    istream_val = 3'b111;
    ostream_rdy = 1'b0;
    #1;
    chk("pre_areset_oval", 64'(ostream_val), 64'(1));
    chk("pre_areset_omsg", 64'(ostream_msg), 64'('h20));
    #1 reset = 1'b0;
    #1;
    chk("areset_oval", 64'(ostream_val), 64'(0));
    chk("areset_omsg", 64'(ostream_msg), 64'(0));
    chk("areset_rdy",  64'(istream_rdy), 64'(0));
    @(negedge clk);
    reset       = 1'b1;
    ostream_rdy = 1'b1;
    #1;
    chk("post_areset_rdy", 64'(istream_rdy), 64'(3'b001));
    @(negedge clk);
    istream_val = 3'b000;
    #1;
    chk("post_areset_omsg", 64'(ostream_msg), 64'('h10));
    chk("post_areset_oval", 64'(ostream_val), 64'(1));

    // random traffic from a fresh reset
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_val = 0; m_msg = '0; m_prio = 0;
    for (int n = 0; n < 600; n++) begin
      int best, bestd, d;
      logic [2:0] exp_rdy;
      @(negedge clk);
      istream_val = 3'($urandom);
      for (int p = 0; p < 3; p++) istream_msg[p] = W'({$urandom, $urandom});
      ostream_rdy = ($urandom_range(0, 3) != 0);
      #1;
      // winner = valid input at the smallest cyclic distance from the pointer
      best = -1; bestd = 4;
      if (!m_val || ostream_rdy) begin
        for (int p = 0; p < 3; p++) begin
          d = (p - m_prio + 3) % 3;
          if (istream_val[p] && d < bestd) begin bestd = d; best = p; end
        end
      end
      exp_rdy = (best < 0) ? 3'b000 : 3'(1 << best);
      chk($sformatf("rnd%0d_rdy", n),  64'(istream_rdy), 64'(exp_rdy));
      chk($sformatf("rnd%0d_oval", n), 64'(ostream_val), 64'(m_val));
      chk($sformatf("rnd%0d_omsg", n), 64'(ostream_msg), 64'(m_msg));
      if (best >= 0) begin
        m_msg  = istream_msg[best];
        m_val  = 1;
        m_prio = (best + 1) % 3;
      end else if (m_val && ostream_rdy) begin
        m_val = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
